// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: cpustate encodings, arbiter FSM states and grant identifiers.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_IN    = 2'b01,
        ST_CHECK = 2'b10,
        ST_RUN   = 2'b11
    } cpustate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_HOST = 1'b1
    } grant_t;

    localparam int CNT_W = 3;

    // The CPU may only use the memory port while the machine is running.
    function automatic logic cpu_eligible(input logic [1:0] state, input logic req);
        return req && (state == ST_RUN);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, host and memory-side signals around the shared memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [1:0]    cpustate;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  cpustate,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpustate,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: on contention the requester that did not win last goes next.
module rr_pick2
    import cpu_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   host_req_i,
    input  grant_t last_grant_i,
    output logic   any_o,
    output grant_t grant_o
);

    // Winner selection; with no request the output simply follows last_grant_i.
    always_comb begin
        any_o   = cpu_req_i | host_req_i;
        grant_o = last_grant_i;
        if (cpu_req_i && host_req_i) begin
            grant_o = (last_grant_i == GRANT_CPU) ? GRANT_HOST : GRANT_CPU;
        end else if (cpu_req_i) begin
            grant_o = GRANT_CPU;
        end else if (host_req_i) begin
            grant_o = GRANT_HOST;
        end else begin
            grant_o = last_grant_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU bus and the host loader: grant, one access, wait for
// read data, then a one-cycle ack with data back to the winner.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus_if
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    grant_t           last_grant_q, last_grant_d;
    grant_t           owner_q, owner_d;
    logic             mem_cs_q, mem_cs_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             host_ack_q, host_ack_d;
    logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]    host_rdata_q, host_rdata_d;
    logic             busy_q, busy_d;

    logic             cpu_elig_s;
    logic             pick_any_s;
    grant_t           pick_s;

    assign cpu_elig_s = cpu_eligible(bus_if.cpustate, bus_if.cpu_req);

    rr_pick2 u_pick (
        .cpu_req_i    (cpu_elig_s),
        .host_req_i   (bus_if.host_req),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any_s),
        .grant_o      (pick_s)
    );

    // Next-state and registered-output logic; the mem_* registers double as the request capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        mem_cs_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = {AW{1'b0}};
        mem_wdata_d  = {DW{1'b0}};
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d      = ISSUE;
                    owner_d      = pick_s;
                    last_grant_d = pick_s;
                    mem_cs_d     = 1'b1;
                    if (pick_s == GRANT_CPU) begin
                        mem_we_d    = bus_if.cpu_we;
                        mem_addr_d  = bus_if.cpu_addr;
                        mem_wdata_d = bus_if.cpu_wdata;
                    end else begin
                        mem_we_d    = bus_if.host_we;
                        mem_addr_d  = bus_if.host_addr;
                        mem_wdata_d = bus_if.host_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d    = RESP;
                    cpu_ack_d  = (owner_q == GRANT_CPU);
                    host_ack_d = (owner_q == GRANT_HOST);
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d    = RESP;
                    cpu_ack_d  = (owner_q == GRANT_CPU);
                    host_ack_d = (owner_q == GRANT_HOST);
                    if (owner_q == GRANT_CPU) begin
                        cpu_rdata_d = bus_if.mem_rdata;
                    end else begin
                        host_rdata_d = bus_if.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access in flight without an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_grant_q <= GRANT_HOST;
            owner_q      <= GRANT_HOST;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            mem_wdata_q  <= {DW{1'b0}};
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= {DW{1'b0}};
            host_rdata_q <= {DW{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_if.mem_cs     = mem_cs_q;
    assign bus_if.mem_we     = mem_we_q;
    assign bus_if.mem_addr   = mem_addr_q;
    assign bus_if.mem_wdata  = mem_wdata_q;
    assign bus_if.cpu_ack    = cpu_ack_q;
    assign bus_if.host_ack   = host_ack_q;
    assign bus_if.cpu_rdata  = cpu_rdata_q;
    assign bus_if.host_rdata = host_rdata_q;
    assign bus_if.busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3, each with a small memory model.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    mem_port_arbiter_if #(.AW(16), .DW(8)) if1 ();
    mem_port_arbiter_if #(.AW(16), .DW(8)) if3 ();

    mem_port_arbiter #(.AW(16), .DW(8), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus_if(if1));
    mem_port_arbiter #(.AW(16), .DW(8), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus_if(if3));

    always #5 clk = ~clk;

    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] rd1;
    logic [7:0] rd3 [3];

    // Memory models; preloaded locations are (re)written whenever reset is held over an edge.
    always @(posedge clk) begin
        if (rst) begin
            mem1[8'h20] <= 8'h5E;
            mem1[8'h30] <= 8'h11;
            mem1[8'h31] <= 8'h22;
            mem1[8'h40] <= 8'h77;
            mem3[8'hFF] <= 8'h3C;
        end else begin
            if (if1.mem_cs && if1.mem_we) mem1[if1.mem_addr[7:0]] <= if1.mem_wdata;
            if (if3.mem_cs && if3.mem_we) mem3[if3.mem_addr[7:0]] <= if3.mem_wdata;
        end
        if (if1.mem_cs && !if1.mem_we) rd1 <= mem1[if1.mem_addr[7:0]];
        if (if3.mem_cs && !if3.mem_we) rd3[0] <= mem3[if3.mem_addr[7:0]];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    assign if1.mem_rdata = rd1;
    assign if3.mem_rdata = rd3[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host access on the MEM_LAT=1 instance; call at a negedge while it is IDLE.
    task automatic host1(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                         input int exp_lat, input logic [7:0] exp_rd);
        int n;
        bit got;
        if1.host_req = 1'b1; if1.host_we = we; if1.host_addr = addr; if1.host_wdata = wdata;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (n == 1) begin
                check_val("h_cs", if1.mem_cs, 1'b1);
                check_val("h_we", if1.mem_we, we);
                check_val("h_addr", if1.mem_addr, addr);
                check_val("h_wdata", if1.mem_wdata, wdata);
            end
            if (if1.host_ack) got = 1'b1;
        end
        if1.host_req = 1'b0;
        check_val("h_lat", n, exp_lat);
        if (!we) check_val("h_rdata", if1.host_rdata, exp_rd);
    endtask

    // CPU access on the MEM_LAT=1 instance; call at a negedge while it is IDLE.
    task automatic cpu1(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        input int exp_lat, input logic [7:0] exp_rd);
        int n;
        bit got;
        if1.cpu_req = 1'b1; if1.cpu_we = we; if1.cpu_addr = addr; if1.cpu_wdata = wdata;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (n == 1) begin
                check_val("c_cs", if1.mem_cs, 1'b1);
                check_val("c_addr", if1.mem_addr, addr);
            end
            if (if1.cpu_ack) got = 1'b1;
        end
        if1.cpu_req = 1'b0;
        check_val("c_lat", n, exp_lat);
        if (!we) check_val("c_rdata", if1.cpu_rdata, exp_rd);
    endtask

    initial begin
        int n;
        bit got;
        rst = 1'b1;
        if1.cpustate = ST_HALT; if1.cpu_req = 1'b0; if1.cpu_we = 1'b0;
        if1.cpu_addr = 16'h0; if1.cpu_wdata = 8'h0;
        if1.host_req = 1'b0; if1.host_we = 1'b0; if1.host_addr = 16'h0; if1.host_wdata = 8'h0;
        if3.cpustate = ST_HALT; if3.cpu_req = 1'b0; if3.cpu_we = 1'b0;
        if3.cpu_addr = 16'h0; if3.cpu_wdata = 8'h0;
        if3.host_req = 1'b0; if3.host_we = 1'b0; if3.host_addr = 16'h0; if3.host_wdata = 8'h0;
        repeat (2) @(negedge clk);
        check_val("rst_cs", if1.mem_cs, 1'b0);
        check_val("rst_busy", if1.busy, 1'b0);
        check_val("rst_acks", {if1.cpu_ack, if1.host_ack}, 2'b00);
        check_val("rst_rdata", {if1.cpu_rdata, if1.host_rdata}, 16'h0000);
        rst = 1'b0;

        // 1: host write then read-back while loading
        @(negedge clk);
        if1.cpustate = ST_IN;
        host1(1'b1, 16'h0010, 8'hA5, 2, 8'h00);
        @(negedge clk);
        host1(1'b0, 16'h0010, 8'h00, 3, 8'hA5);

        // 2: CPU request blocked outside RUN, granted once RUN is entered
        @(negedge clk);
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("t2_cs", if1.mem_cs, 1'b0);
            check_val("t2_ack", if1.cpu_ack, 1'b0);
        end
        if1.cpustate = ST_RUN;
        cpu1(1'b0, 16'h0020, 8'h00, 3, 8'h5E);

        // 3: both requesting from reset: CPU first, then strict alternation
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 16'h0030;
        if1.host_req = 1'b1; if1.host_we = 1'b0; if1.host_addr = 16'h0031; if1.host_wdata = 8'h00;
        for (int i = 1; i <= 16; i++) begin
            logic       e_cs;
            logic [15:0] e_addr;
            @(negedge clk);
            e_cs   = (i % 4 == 1);
            e_addr = e_cs ? (((i / 4) % 2 == 0) ? 16'h0030 : 16'h0031) : 16'h0000;
            check_val("t3_cs", if1.mem_cs, e_cs);
            check_val("t3_addr", if1.mem_addr, e_addr);
            check_val("t3_we", {if1.mem_we, if1.mem_wdata}, 9'h000);
            check_val("t3_cack", if1.cpu_ack, (i % 8 == 3));
            check_val("t3_hack", if1.host_ack, (i % 8 == 7));
            check_val("t3_busy", if1.busy, (i % 4 != 0));
            if (i % 8 == 3) check_val("t3_crd", if1.cpu_rdata, 8'h11);
            if (i % 8 == 7) check_val("t3_hrd", if1.host_rdata, 8'h22);
        end
        if1.cpu_req = 1'b0; if1.host_req = 1'b0;

        // 4: MEM_LAT=3 host read
        @(negedge clk);
        if3.host_req = 1'b1; if3.host_we = 1'b0; if3.host_addr = 16'h00FF;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (n == 1) check_val("t4_cs", {if3.mem_cs, if3.mem_addr}, {1'b1, 16'h00FF});
            if (if3.host_ack) got = 1'b1;
        end
        if3.host_req = 1'b0;
        check_val("t4_lat", n, 5);
        check_val("t4_rdata", if3.host_rdata, 8'h3C);
        check_val("t4_crd", if3.cpu_rdata, 8'h00);

        // 5: reset during WAIT of a CPU read, then a fresh grant
        @(negedge clk);
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b0; if1.cpu_addr = 16'h0040;
        @(negedge clk);
        check_val("t5_cs", if1.mem_cs, 1'b1);
        @(negedge clk);
        check_val("t5_busy", if1.busy, 1'b1);
        rst = 1'b1;
        #1;
        check_val("t5_rcs", if1.mem_cs, 1'b0);
        check_val("t5_rbusy", if1.busy, 1'b0);
        check_val("t5_rack", if1.cpu_ack, 1'b0);
        check_val("t5_rrd", if1.cpu_rdata, 8'h00);
        @(negedge clk);
        check_val("t5_noack", if1.cpu_ack, 1'b0);
        rst = 1'b0;
        cpu1(1'b0, 16'h0040, 8'h00, 3, 8'h77);

        // 6: inputs change and request drops right after grant
        @(negedge clk);
        if1.cpu_req = 1'b1; if1.cpu_we = 1'b1; if1.cpu_addr = 16'h0050; if1.cpu_wdata = 8'h99;
        @(negedge clk);
        if1.cpu_req = 1'b0; if1.cpu_addr = 16'h0051; if1.cpu_wdata = 8'h66;
        check_val("t6_cs", {if1.mem_cs, if1.mem_we}, 2'b11);
        check_val("t6_addr", if1.mem_addr, 16'h0050);
        check_val("t6_wdata", if1.mem_wdata, 8'h99);
        @(negedge clk);
        check_val("t6_ack", if1.cpu_ack, 1'b1);
        @(negedge clk);
        check_val("t6_ack1", if1.cpu_ack, 1'b0);
        check_val("t6_idle", {if1.mem_cs, if1.busy}, 2'b00);
        check_val("t6_mem", mem1[8'h50], 8'h99);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
